// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the loadable down-counter / interval timer.
// Holds the default counter width and the one-bit state encoding.
package down_counter_timer_pkg;

   localparam int COUNTER_WIDTH = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } timer_state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control and status bundle between a controller and the down-counter timer.
// The controller side uses the master modport; the timer itself uses slave.
interface down_counter_timer_if #(
   parameter int WIDTH = down_counter_timer_pkg::COUNTER_WIDTH
);

   logic             load;
   logic [WIDTH-1:0] d;
   logic             start;
   logic             stop;
   logic             en;
   logic             auto_reload;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output load, d, start, stop, en, auto_reload,
      input  q, busy, done, zero
   );

   modport slave (
      input  load, d, start, stop, en, auto_reload,
      output q, busy, done, zero
   );

endinterface

// File: rtl/down_counter_timer_reg_async_clr.sv
// WIDTH-wide register with asynchronous active-high clear and a load enable.
// Used for both the live count and the reload value.
module reg_async_clr #(
   parameter int WIDTH = down_counter_timer_pkg::COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter with one-shot and auto-reload modes; emits a registered
// one-cycle done pulse when the count reaches zero (or reloads).
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = COUNTER_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   down_counter_timer_if.slave  io
);

   timer_state_t     state;
   timer_state_t     state_next;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic             count_we;
   logic [WIDTH-1:0] reload;
   logic             reload_we;
   logic             done_reg;
   logic             done_next;

   reg_async_clr #(.WIDTH(WIDTH)) u_count_reg (
      .clk (clk),
      .rst (rst),
      .en  (count_we),
      .d   (count_next),
      .q   (count)
   );

   reg_async_clr #(.WIDTH(WIDTH)) u_reload_reg (
      .clk (clk),
      .rst (rst),
      .en  (reload_we),
      .d   (io.d),
      .q   (reload)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         done_reg <= 1'b0;
      end else begin
         state    <= state_next;
         done_reg <= done_next;
      end
   end

   // Priority is load, then stop, then start, then counting; a load or stop on
   // the terminal edge therefore suppresses the done pulse.
   always_comb begin
      state_next = state;
      count_next = count;
      count_we   = 1'b0;
      reload_we  = 1'b0;
      done_next  = 1'b0;

      if (io.load) begin
         count_next = io.d;
         count_we   = 1'b1;
         reload_we  = 1'b1;
         state_next = ST_IDLE;
      end else if (io.stop) begin
         state_next = ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (io.start) begin
            if (count != '0) begin
               state_next = ST_RUN;
            end else begin
               done_next = 1'b1;
            end
         end
      end else if (io.en) begin
         if (count == WIDTH'(1)) begin
            done_next = 1'b1;
            count_we  = 1'b1;
            // A zero reload value would give a zero-length period, so it ends the run.
            if (io.auto_reload && (reload != '0)) begin
               count_next = reload;
            end else begin
               count_next = '0;
               state_next = ST_IDLE;
            end
         end else if (count == '0) begin
            state_next = ST_IDLE;
         end else begin
            count_next = count - WIDTH'(1);
            count_we   = 1'b1;
         end
      end
   end

   assign io.q    = count;
   assign io.busy = (state == ST_RUN);
   assign io.done = done_reg;
   assign io.zero = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer with hand-computed
// expected counts, busy and done values.
module tb_down_counter_timer;

   logic clk;
   logic rst;
   int   check_count;
   int   bad_count;

   down_counter_timer_if #(.WIDTH(16)) bus ();

   down_counter_timer #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         bad_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic load, input logic [15:0] d,
                                input logic start, input logic stop,
                                input logic en, input logic auto_reload);
      bus.load        = load;
      bus.d           = d;
      bus.start       = start;
      bus.stop        = stop;
      bus.en          = en;
      bus.auto_reload = auto_reload;
   endtask

   // Outputs are sampled 1ns after the rising edge, inputs change at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expectState(input string tag, input logic [15:0] q,
                              input logic busy, input logic done);
      checkOutput({tag, " q"}, 32'(bus.q), 32'(q));
      checkOutput({tag, " busy"}, 32'(bus.busy), 32'(busy));
      checkOutput({tag, " done"}, 32'(bus.done), 32'(done));
   endtask

   initial begin
      check_count = 0;
      bad_count   = 0;
      rst         = 1'b1;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      expectState("reset", 16'h0000, 1'b0, 1'b0);
      checkOutput("reset zero", 32'(bus.zero), 32'd1);
      rst = 1'b0;
      step();

      // Clear mid-run takes effect without waiting for a clock edge
      applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expectState("clr prerun", 16'h0123, 1'b1, 1'b0);
      checkOutput("clr prerun zero", 32'(bus.zero), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      expectState("clr async", 16'h0000, 1'b0, 1'b0);
      checkOutput("clr async zero", 32'(bus.zero), 32'd1);
      step();
      rst = 1'b0;
      step();

      // One-shot count from 3
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expectState("os load", 16'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      expectState("os start", 16'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      expectState("os q2", 16'd2, 1'b1, 1'b0);
      step();
      expectState("os q1", 16'd1, 1'b1, 1'b0);
      step();
      expectState("os q0", 16'd0, 1'b0, 1'b1);
      checkOutput("os zero", 32'(bus.zero), 32'd1);
      step();
      expectState("os after", 16'd0, 1'b0, 1'b0);

      // Auto-reload with period 2, then drop auto_reload before the last terminal
      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      expectState("ar start", 16'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         expectState("ar q1", 16'd1, 1'b1, 1'b0);
         step();
         expectState("ar reload", 16'd2, 1'b1, 1'b1);
      end
      step();
      expectState("ar q1 last", 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      expectState("ar oneshot end", 16'd0, 1'b0, 1'b1);

      // Enable gating: en pattern 1,0,0,1,1,1 from 4
      applyStimulus(1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expectState("en start", 16'd4, 1'b1, 1'b0);
      begin
         logic        en_pat   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
         logic [15:0] q_pat    [6] = '{16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
         logic        done_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         logic        busy_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, en_pat[i], 1'b0);
            step();
            expectState($sformatf("en step%0d", i), q_pat[i], busy_pat[i], done_pat[i]);
         end
      end

      // Stop on the terminal edge wins over the count
      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      expectState("stop q1", 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      expectState("stop term", 16'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      expectState("stop hold", 16'd1, 1'b0, 1'b0);

      // Load on the terminal edge wins over the count
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expectState("ld restart", 16'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      expectState("ld term", 16'hFFFF, 1'b0, 1'b0);

      // Zero start gives a done pulse without ever running
      applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      expectState("zs pulse", 16'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      expectState("zs after", 16'd0, 1'b0, 1'b0);

      // Start while running is ignored and counting continues
      applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expectState("rs start", 16'd5, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      expectState("rs q4", 16'd4, 1'b1, 1'b0);
      step();
      expectState("rs q3", 16'd3, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", check_count, bad_count);
      $finish;
   end

endmodule
